// File: rtl/rtype_encoder.sv
// R-type instruction encoder feeding a small valid/ready FIFO.
// Define RTYPE_W_OPS_EN to enable the subw/sraw (0111011) encodings.
module rtype_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op_sel,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  input  logic [4:0]       rd_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [AW:0]      fill,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [6:0] OPC = 7'b0110011;
  localparam logic [6:0] OPC_W = 7'b0111011;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  logic        op_legal;
  logic [2:0]  fun3;
  logic [6:0]  fun7;
  logic [6:0]  opcode;
  logic [31:0] word;

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [31:0] mem [DEPTH];
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        ill_acc;

  always_comb begin
    op_legal = 1'b1;
    fun3     = 3'b000;
    fun7     = 7'b0000000;
    opcode   = OPC;
    unique case (op_sel)
      4'd0: fun3 = 3'b000;
      4'd1: begin fun3 = 3'b000; fun7 = F7_ALT; end
      4'd2: fun3 = 3'b001;
      4'd3: fun3 = 3'b010;
      4'd4: fun3 = 3'b011;
      4'd5: fun3 = 3'b100;
      4'd6: fun3 = 3'b101;
      4'd7: begin fun3 = 3'b101; fun7 = F7_ALT; end
      4'd8: fun3 = 3'b110;
      4'd9: fun3 = 3'b111;
`ifdef RTYPE_W_OPS_EN
      4'd10: begin
        fun3   = 3'b000;
        fun7   = F7_ALT;
        opcode = OPC_W;
      end
      4'd11: begin
        fun3   = 3'b101;
        fun7   = F7_ALT;
        opcode = OPC_W;
      end
`endif
      default: op_legal = 1'b0;
    endcase
  end

  assign word = {fun7, rs2_addr, rs1_addr, fun3, rd_addr, opcode};

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  // Illegal requests never touch storage, so they bypass the full check.
  assign in_ready = !full || !op_legal;
  assign push     = in_valid && in_ready && op_legal;
  assign ill_acc  = in_valid && !op_legal;
  assign pop      = !empty && out_ready;

  assign out_valid = !empty;
  assign out_instr = empty ? 32'h0 : mem[rptr[AW-1:0]];
  assign fill      = wptr - rptr;

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      illegal     <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      illegal <= ill_acc;
      if (ill_acc && illegal_cnt != '1)
        illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rtype_encoder.sv
// Directed bench for rtype_encoder with a queue-based reference model.
// Every cycle the DUT outputs are compared against the model.
module tb_rtype_encoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int AW = $clog2(DEPTH);
  localparam int CMAX = (1 << CNT_W) - 1;

  logic             clk = 0;
  logic             rst_n = 0;
  logic             in_valid = 0;
  logic             in_ready;
  logic [3:0]       op_sel = 0;
  logic [4:0]       rs1_addr = 0;
  logic [4:0]       rs2_addr = 0;
  logic [4:0]       rd_addr = 0;
  logic             out_valid;
  logic             out_ready = 0;
  logic [31:0]      out_instr;
  logic [AW:0]      fill;
  logic             illegal;
  logic [CNT_W-1:0] illegal_cnt;

  int checks = 0;
  int errors = 0;

  rtype_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .fill(fill),
    .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  int f3_tab [12] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7, 0, 5};

  function automatic bit legal_op(int op);
`ifdef RTYPE_W_OPS_EN
    return op <= 11;
`else
    return op <= 9;
`endif
  endfunction

  function automatic logic [31:0] enc(int op, int r1, int r2, int rd);
    int alt;
    int opc;
    alt = (op == 1 || op == 7 || op >= 10) ? 32 : 0;
    opc = (op >= 10) ? 'h3B : 'h33;
    return (alt << 25) + (r2 << 20) + (r1 << 15) +
           (f3_tab[op] << 12) + (rd << 7) + opc;
  endfunction

  logic [31:0] q [$];
  int  cnt_m;
  bit  ill_m;
  bit  m_leg;
  bit  m_acc;
  bit  m_pop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      cnt_m = 0;
      ill_m = 0;
    end else begin
      m_leg = legal_op(int'(op_sel));
      m_acc = in_valid && (!m_leg || q.size() < DEPTH);
      m_pop = q.size() > 0 && out_ready;
      ill_m = in_valid && !m_leg;
      if (ill_m && cnt_m < CMAX) cnt_m++;
      if (m_pop) void'(q.pop_front());
      if (m_acc && m_leg)
        q.push_back(enc(op_sel, rs1_addr, rs2_addr, rd_addr));
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_out_valid", out_valid, q.size() != 0);
      chk("m_out_instr", out_instr, q.size() != 0 ? q[0] : 32'h0);
      chk("m_fill", fill, q.size());
      chk("m_in_ready", in_ready,
          q.size() < DEPTH || !legal_op(int'(op_sel)));
      chk("m_illegal", illegal, ill_m);
      chk("m_illegal_cnt", illegal_cnt, cnt_m);
    end
  end

  task automatic do_reset();
    in_valid = 0;
    out_ready = 0;
    #2 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic push(int op, int r1, int r2, int rd);
    op_sel = op[3:0];
    rs1_addr = r1[4:0];
    rs2_addr = r2[4:0];
    rd_addr = rd[4:0];
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fill", fill, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_illegal", illegal, 0);
    chk("rst_cnt", illegal_cnt, 0);

    @(posedge clk); #1;
    push(0, 1, 2, 3);
    @(negedge clk);
    chk("add_valid", out_valid, 1);
    chk("add_instr", out_instr, 32'h002081B3);
    chk("add_fill", fill, 1);

    do_reset();
    push(1, 5, 6, 7);
    @(negedge clk);
    chk("sub_instr", out_instr, 32'h406283B3);

    do_reset();
    push(11, 1, 2, 3);
    @(negedge clk);
`ifdef RTYPE_W_OPS_EN
    chk("sraw_instr", out_instr, 32'h4020D1BB);
    chk("sraw_illegal", illegal, 0);
`else
    chk("sraw_illegal", illegal, 1);
    chk("sraw_cnt", illegal_cnt, 1);
    chk("sraw_fill", fill, 0);
`endif
    @(posedge clk); #1;
    @(negedge clk);
    chk("illegal_one_shot", illegal, 0);

    do_reset();
    for (int i = 0; i < DEPTH; i++) push(i + 2, i, i + 8, i + 16);
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    chk("full_fill", fill, DEPTH);
    push(9, 3, 4, 5);
    @(negedge clk);
    chk("full_refused", fill, DEPTH);
    chk("full_head", out_instr, enc(2, 0, 8, 16));
    out_ready = 1;
    repeat (DEPTH) @(posedge clk);
    #1 out_ready = 0;
    @(negedge clk);
    chk("drain_valid", out_valid, 0);
    chk("drain_instr", out_instr, 32'h0);

    do_reset();
    push(5, 1, 1, 1);
    push(8, 2, 2, 2);
    out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      op_sel = 4'(i % 10);
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      rd_addr = 5'(i + 3);
      in_valid = 1;
      @(negedge clk);
      chk("stream_fill", fill, 2);
      @(posedge clk); #1;
    end
    in_valid = 0;
    out_ready = 0;

    do_reset();
    push(0, 9, 9, 0);
    op_sel = 4'd15;
    in_valid = 1;
    repeat (300) @(posedge clk);
    #1 in_valid = 0;
    @(negedge clk);
    chk("sat_cnt", illegal_cnt, CMAX);
    chk("sat_fill", fill, 1);
    chk("sat_head", out_instr, 32'h00948033);

    do_reset();
    for (int i = 0; i < 3; i++) push(i, i, i, i);
    @(negedge clk);
    chk("pre_rst_fill", fill, 3);
    #2 rst_n = 0;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_fill", fill, 0);
    chk("async_cnt", illegal_cnt, 0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
